// File: rtl/mcu_bus_transmitter_pkg.sv
// Shared definitions for the MCU parallel-bus transmitter: FSM encodings,
// byte-tag constants, the queued entry layout and the phase-reload helper.
package mcu_bus_transmitter_pkg;

   localparam logic [1:0] MCU_TX_IDLE  = 2'd0;
   localparam logic [1:0] MCU_TX_SETUP = 2'd1;
   localparam logic [1:0] MCU_TX_HIGH  = 2'd2;
   localparam logic [1:0] MCU_TX_HOLD  = 2'd3;

   localparam logic MCU_BUS_COMMAND = 1'b1;
   localparam logic MCU_BUS_DATA    = 1'b0;

   typedef struct packed {
      logic       is_command;
      logic [7:0] data;
   } mcu_tx_entry_t;

   // Each bus phase lasts DIVIDER cycles, counted down to zero from DIVIDER-1.
   function automatic logic [7:0] phase_reload(input int divider);
      return 8'(divider - 1);
   endfunction

endpackage

// File: rtl/mcu_bus_tx_fifo.sv
// Synchronous transmit FIFO holding tagged bytes; the head entry is visible
// combinationally so the bus driver can capture it on the pop edge.
module mcu_bus_tx_fifo
   import mcu_bus_transmitter_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
)(
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  mcu_tx_entry_t wdata_i,
   output mcu_tx_entry_t rdata_o,
   output logic [LW-1:0] level_o
);

   mcu_tx_entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + LW'(push_i) - LW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // On a full push+pop the write lands in the slot being read out this cycle.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/mcu_bus_transmitter.sv
// Initiator for the 8-bit MCU parallel bus: SETUP / HIGH / HOLD strobe cycle per byte.
// Define MCU_BUS_TX_FIFO_EN for a FIFO_DEPTH-deep queue with back-to-back cycles.
module mcu_bus_transmitter
   import mcu_bus_transmitter_pkg::*;
#(
   parameter  int DIVIDER    = 4,
   parameter  int FIFO_DEPTH = 8,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
)(
   input  logic          system_clock,
   input  logic          reset_n,
   input  logic [7:0]    tx_data,
   input  logic          tx_is_command,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic          mcu_bus_clock,
   output logic [7:0]    mcu_bus_out,
   output logic          mcu_bus_oe,
   output logic          mcu_bus_command_data,
   output logic          busy,
   output logic [LW-1:0] fifo_level
);

   localparam logic [7:0] PHASE_RELOAD = phase_reload(DIVIDER);

   logic [1:0]    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    bus_q, bus_d;
   logic          cmd_q, cmd_d;
   logic          clk_q, oe_q, busy_q;

   mcu_tx_entry_t wr_entry_s, head_s;
   logic          avail_s, push_s, pop_s;
   logic [LW-1:0] level_s, level_nxt_s;

   assign wr_entry_s  = {tx_is_command, tx_data};
   assign push_s      = tx_valid && tx_ready;
   assign level_nxt_s = level_s + LW'(push_s) - LW'(pop_s);

`ifdef MCU_BUS_TX_FIFO_EN
   localparam logic B2B_EN = 1'b1;

   // A pop frees the slot a same-cycle push lands in, so a full FIFO keeps accepting.
   assign tx_ready = reset_n && ((level_s != LW'(FIFO_DEPTH)) || pop_s);
   assign avail_s  = (level_s != LW'(0));

   mcu_bus_tx_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (system_clock),
      .rst_n_i (reset_n),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (wr_entry_s),
      .rdata_o (head_s),
      .level_o (level_s)
   );
`else
   localparam logic B2B_EN = 1'b0;

   mcu_tx_entry_t hold_q, hold_d;
   logic          hold_valid_q, hold_valid_d;

   assign tx_ready = reset_n && (state_q == MCU_TX_IDLE) && !hold_valid_q;
   assign avail_s  = hold_valid_q;
   assign head_s   = hold_q;
   assign level_s  = {{(LW-1){1'b0}}, hold_valid_q};

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (push_s) begin
         hold_d       = wr_entry_s;
         hold_valid_d = 1'b1;
      end else if (pop_s) begin
         hold_valid_d = 1'b0;
      end else begin
         hold_valid_d = hold_valid_q;
      end
   end

   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end
`endif

   assign pop_s = avail_s && ((state_q == MCU_TX_IDLE) ||
                              (B2B_EN && (state_q == MCU_TX_HOLD)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bus_d   = bus_q;
      cmd_d   = cmd_q;
      case (state_q)
         MCU_TX_IDLE: begin
            if (pop_s) begin
               state_d        = MCU_TX_SETUP;
               cnt_d          = PHASE_RELOAD;
               {cmd_d, bus_d} = head_s;
            end else begin
               state_d = MCU_TX_IDLE;
            end
         end
         MCU_TX_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = MCU_TX_HIGH;
               cnt_d   = PHASE_RELOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         MCU_TX_HIGH: begin
            if (cnt_q == 8'd0) begin
               state_d = MCU_TX_HOLD;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         MCU_TX_HOLD: begin
            if (pop_s) begin
               state_d        = MCU_TX_SETUP;
               cnt_d          = PHASE_RELOAD;
               {cmd_d, bus_d} = head_s;
            end else begin
               state_d = MCU_TX_IDLE;
            end
         end
         default: begin
            state_d = MCU_TX_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Strobe, enable and busy are decoded from next state so each is a clean flop output.
   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         state_q <= MCU_TX_IDLE;
         cnt_q   <= 8'd0;
         bus_q   <= 8'h00;
         cmd_q   <= MCU_BUS_DATA;
         clk_q   <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bus_q   <= bus_d;
         cmd_q   <= cmd_d;
         clk_q   <= (state_d == MCU_TX_HIGH);
         oe_q    <= (state_d != MCU_TX_IDLE);
         busy_q  <= (state_d != MCU_TX_IDLE) || (level_nxt_s != LW'(0));
      end
   end

   assign mcu_bus_clock        = clk_q;
   assign mcu_bus_out          = bus_q;
   assign mcu_bus_oe           = oe_q;
   assign mcu_bus_command_data = cmd_q;
   assign busy                 = busy_q;
   assign fifo_level           = level_s;

endmodule

// File: tb/tb_mcu_bus_transmitter.sv
// Directed bench for mcu_bus_transmitter (DIVIDER=4 instance plus a DIVIDER=1 instance);
// expectations follow MCU_BUS_TX_FIFO_EN the same way the design does.
module tb_mcu_bus_transmitter;
   import mcu_bus_transmitter_pkg::*;

   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    tx_data, d1_data;
   logic          tx_is_command, tx_valid, d1_cmd, d1_valid;
   logic          tx_ready, mcu_bus_clock, mcu_bus_oe, mcu_bus_command_data, busy;
   logic [7:0]    mcu_bus_out;
   logic [LW-1:0] fifo_level;
   logic          d1_ready, d1_bclk, d1_oe, d1_tag, d1_busy;
   logic [7:0]    d1_out;
   logic [LW-1:0] d1_level;
   wire  [7:0]    mcu_bus, d1_bus;

   always #5 clk = ~clk;

   assign mcu_bus = mcu_bus_oe ? mcu_bus_out : 8'hzz;
   assign d1_bus  = d1_oe ? d1_out : 8'hzz;

   mcu_bus_transmitter #(.DIVIDER(4), .FIFO_DEPTH(8)) dut (
      .system_clock(clk), .reset_n(reset_n), .tx_data(tx_data),
      .tx_is_command(tx_is_command), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mcu_bus_clock(mcu_bus_clock), .mcu_bus_out(mcu_bus_out), .mcu_bus_oe(mcu_bus_oe),
      .mcu_bus_command_data(mcu_bus_command_data), .busy(busy), .fifo_level(fifo_level)
   );

   mcu_bus_transmitter #(.DIVIDER(1), .FIFO_DEPTH(8)) dut1 (
      .system_clock(clk), .reset_n(reset_n), .tx_data(d1_data),
      .tx_is_command(d1_cmd), .tx_valid(d1_valid), .tx_ready(d1_ready),
      .mcu_bus_clock(d1_bclk), .mcu_bus_out(d1_out), .mcu_bus_oe(d1_oe),
      .mcu_bus_command_data(d1_tag), .busy(d1_busy), .fifo_level(d1_level)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Receiver model: capture {tag, bus} on every rising edge of the bus strobe.
   logic [8:0] rx_q[$];
   int         rise_q[$];
   logic [8:0] rx1_q[$];
   int         rise1_q[$];
   int         cyc = 0;
   logic       prev_bclk = 1'b0;
   logic       prev_d1clk = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mcu_bus_clock && !prev_bclk) begin
         rx_q.push_back({mcu_bus_command_data, mcu_bus});
         rise_q.push_back(cyc);
      end
      if (d1_bclk && !prev_d1clk) begin
         rx1_q.push_back({d1_tag, d1_bus});
         rise1_q.push_back(cyc);
      end
      prev_bclk  <= mcu_bus_clock;
      prev_d1clk <= d1_bclk;
   end

   int   max_level = 0;
   int   ready_in_xfer = 0;
   int   oe_falls = 0;
   logic prev_oe = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (mcu_bus_oe && tx_ready) ready_in_xfer++;
      if (prev_oe && !mcu_bus_oe) oe_falls++;
      prev_oe = mcu_bus_oe;
   endtask

   task automatic push(input logic [7:0] d, input logic c);
      int n = 0;
      while (!tx_ready && n < 200) begin
         step();
         n++;
      end
      check("push_ready", 32'(tx_ready), 32'd1);
      tx_data = d;
      tx_is_command = c;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
   endtask

   task automatic push1(input logic [7:0] d, input logic c);
      int n = 0;
      while (!d1_ready && n < 200) begin
         step();
         n++;
      end
      check("push1_ready", 32'(d1_ready), 32'd1);
      d1_data = d;
      d1_cmd = c;
      d1_valid = 1'b1;
      step();
      d1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || mcu_bus_oe || d1_busy || d1_oe) && n < 500) begin
         step();
         n++;
      end
      check("idle_timeout", 32'(n < 500), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, base1, n, k, extra, min_full, exp_div1_gap;
      logic exp_rdy, reached, saw_low;

      reset_n = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00; tx_is_command = 1'b0;
      d1_valid = 1'b0; d1_data = 8'h00; d1_cmd = 1'b0;
      step();
      step();
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_bclk", 32'(mcu_bus_clock), 32'd0);
      check("rst_out", 32'(mcu_bus_out), 32'h00);
      check("rst_oe", 32'(mcu_bus_oe), 32'd0);
      check("rst_tag", 32'(mcu_bus_command_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      reset_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(tx_ready), 32'd1);

      // Single command byte, cycle-by-cycle waveform after acceptance.
      base = rx_q.size();
      push(8'h02, MCU_BUS_COMMAND);
      check("single_level_acc", 32'(fifo_level), 32'd1);
      check("single_busy_acc", 32'(busy), 32'd1);
      check("single_oe_acc", 32'(mcu_bus_oe), 32'd0);
      for (k = 1; k <= 10; k++) begin
         step();
`ifdef MCU_BUS_TX_FIFO_EN
         exp_rdy = 1'b1;
`else
         exp_rdy = (k == 10);
`endif
         check($sformatf("single_bclk_%0d", k), 32'(mcu_bus_clock), 32'((k >= 5) && (k <= 8)));
         check($sformatf("single_oe_%0d", k), 32'(mcu_bus_oe), 32'(k <= 9));
         check($sformatf("single_out_%0d", k), 32'(mcu_bus_out), 32'h02);
         check($sformatf("single_tag_%0d", k), 32'(mcu_bus_command_data), 32'd1);
         check($sformatf("single_ready_%0d", k), 32'(tx_ready), 32'(exp_rdy));
      end
      check("single_busy_end", 32'(busy), 32'd0);
      check("single_rx_count", 32'(rx_q.size() - base), 32'd1);
      check("single_rx_byte", 32'(rx_q[base]), 32'h102);

      // DIVIDER=1 instance: two bytes through the receiver model.
      base1 = rx1_q.size();
      push1(8'hA5, MCU_BUS_DATA);
      push1(8'h5A, MCU_BUS_COMMAND);
      wait_idle();
`ifdef MCU_BUS_TX_FIFO_EN
      exp_div1_gap = 3;
`else
      exp_div1_gap = 5;
`endif
      check("div1_rx_count", 32'(rx1_q.size() - base1), 32'd2);
      check("div1_rx0", 32'(rx1_q[base1]), 32'h0A5);
      check("div1_rx1", 32'(rx1_q[base1 + 1]), 32'h15A);
      check("div1_gap", 32'(rise1_q[base1 + 1] - rise1_q[base1]), 32'(exp_div1_gap));

`ifdef MCU_BUS_TX_FIFO_EN
      // Burst of eight data bytes pushed on consecutive cycles.
      base = rx_q.size();
      max_level = 0;
      oe_falls = 0;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), MCU_BUS_DATA);
      wait_idle();
      check("burst_count", 32'(rx_q.size() - base), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("burst_rx_%0d", i), 32'(rx_q[base + i]), 32'h010 + 32'(i));
         if (i > 0) check($sformatf("burst_gap_%0d", i), 32'(rise_q[base + i] - rise_q[base + i - 1]), 32'd9);
      end
      check("burst_oe_falls", 32'(oe_falls), 32'd1);
      check("burst_max_level", 32'(max_level), 32'd7);

      // Continuous valid until 20 bytes are taken; FIFO must sit at 8 across pops.
      base = rx_q.size();
      max_level = 0;
      reached = 1'b0;
      saw_low = 1'b0;
      min_full = 99;
      tx_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tx_data = 8'h40 + 8'(i);
         tx_is_command = 1'(i & 1);
         n = 0;
         while (!tx_ready && n < 200) begin
            saw_low = 1'b1;
            check("full_level_not_ready", 32'(fifo_level), 32'd8);
            step();
            n++;
         end
         step();
         if (fifo_level == 4'd8) reached = 1'b1;
         if (reached && (int'(fifo_level) < min_full)) min_full = int'(fifo_level);
      end
      tx_valid = 1'b0;
      wait_idle();
      check("full_reached", 32'(reached), 32'd1);
      check("full_saw_not_ready", 32'(saw_low), 32'd1);
      check("full_min_level", 32'(min_full), 32'd8);
      check("full_max_level", 32'(max_level), 32'd8);
      check("full_count", 32'(rx_q.size() - base), 32'd20);
      for (int i = 0; i < 20; i++)
         check($sformatf("full_rx_%0d", i), 32'(rx_q[base + i]), 32'((i & 1) << 8) + 32'h40 + 32'(i));
`else
      // Three bytes through the single holding register.
      base = rx_q.size();
      max_level = 0;
      oe_falls = 0;
      ready_in_xfer = 0;
      push(8'h81, MCU_BUS_COMMAND);
      push(8'h82, MCU_BUS_DATA);
      push(8'h83, MCU_BUS_COMMAND);
      wait_idle();
      check("hold_count", 32'(rx_q.size() - base), 32'd3);
      check("hold_rx0", 32'(rx_q[base]), 32'h181);
      check("hold_rx1", 32'(rx_q[base + 1]), 32'h082);
      check("hold_rx2", 32'(rx_q[base + 2]), 32'h183);
      check("hold_gap1", 32'(rise_q[base + 1] - rise_q[base]), 32'd11);
      check("hold_gap2", 32'(rise_q[base + 2] - rise_q[base + 1]), 32'd11);
      check("hold_oe_falls", 32'(oe_falls), 32'd3);
      check("hold_max_level", 32'(max_level), 32'd1);
      check("hold_ready_in_xfer", 32'(ready_in_xfer), 32'd0);
`endif

      // Reset during HIGH abandons the cycle and flushes anything queued.
      base = rx_q.size();
      push(8'h33, MCU_BUS_DATA);
`ifdef MCU_BUS_TX_FIFO_EN
      push(8'h34, MCU_BUS_COMMAND);
`endif
      n = 0;
      while (!mcu_bus_clock && n < 50) begin
         step();
         n++;
      end
      check("mid_reach_high", 32'(mcu_bus_clock), 32'd1);
      step();
      check("mid_still_high", 32'(mcu_bus_clock), 32'd1);
      reset_n = 1'b0;
      step();
      check("mid_ready_in_rst", 32'(tx_ready), 32'd0);
      check("mid_bclk", 32'(mcu_bus_clock), 32'd0);
      check("mid_oe", 32'(mcu_bus_oe), 32'd0);
      check("mid_level", 32'(fifo_level), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      extra = 0;
      for (k = 0; k < 20; k++) begin
         step();
         if (mcu_bus_clock || mcu_bus_oe) extra++;
      end
      check("mid_no_activity", 32'(extra), 32'd0);
      check("mid_rx_count", 32'(rx_q.size() - base), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
